terrain_buffer_writer: RTL and testbench

TERRAIN_BUFFER_WRITER -- requirements
Module: terrain_buffer_writer

---
 rtl/terrain_buffer_writer.sv | 108 ++++++++++
 tb/tb_terrain_buffer_writer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/terrain_buffer_writer.sv
// Double-buffered terrain column writer: fills the back buffer one column per
// accepted sample, then swaps front/back on the next end-of-frame pulse.
module terrain_buffer_writer #(
    parameter int COLS  = 160,
    parameter int Y_MAX = 119
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] y_in,
    input  logic       y_valid,
    input  logic       frame_done,
    output logic       ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       ram1_we,
    output logic       ram2_we,
    output logic       front_sel,
    output logic       drop,
    output logic [7:0] swap_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_e;

    localparam logic [7:0] LAST_COL = 8'(COLS - 1);
    localparam logic [7:0] Y_CLAMP  = 8'(Y_MAX);

    state_e     state_q;
    logic [7:0] col_q;
    logic [7:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic [7:0] wr_data_d;
    logic       ram1_we_q;
    logic       ram2_we_q;
    logic       front_sel_q;
    logic       drop_q;
    logic [7:0] swap_count_q;

    assign wr_data_d = (y_in > Y_CLAMP) ? Y_CLAMP : y_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= 8'd0;
            wr_addr_q    <= 8'd0;
            wr_data_q    <= 8'd0;
            ram1_we_q    <= 1'b0;
            ram2_we_q    <= 1'b0;
            front_sel_q  <= 1'b0;
            drop_q       <= 1'b0;
            swap_count_q <= 8'd0;
        end else begin
            // NOTE: write-enables default low every cycle so each accepted sample yields exactly one pulse.
            ram1_we_q <= 1'b0;
            ram2_we_q <= 1'b0;
            drop_q    <= y_valid && (state_q != FILL);

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FILL;
                        col_q   <= 8'd0;
                    end
                end

                FILL: begin
                    if (y_valid) begin
                        wr_addr_q <= col_q;
                        wr_data_q <= wr_data_d;
                        // Only the back buffer (the one not being displayed) is written.
                        ram1_we_q <= front_sel_q;
                        ram2_we_q <= ~front_sel_q;
                        if (col_q == LAST_COL) begin
                            state_q <= WAIT_SWAP;
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end

                WAIT_SWAP: begin
                    if (frame_done) begin
                        front_sel_q  <= ~front_sel_q;
                        swap_count_q <= swap_count_q + 8'd1;
                        col_q        <= 8'd0;
                        state_q      <= FILL;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready      = (state_q == FILL);
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign ram1_we    = ram1_we_q;
    assign ram2_we    = ram2_we_q;
    assign front_sel  = front_sel_q;
    assign drop       = drop_q;
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_terrain_buffer_writer.sv
// Directed bench for terrain_buffer_writer: fills, swaps, ignored frame_done,
// drops in WAIT_SWAP/IDLE and asynchronous reset mid-fill.
module tb_terrain_buffer_writer;

    localparam int COLS  = 160;
    localparam int Y_MAX = 119;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] y_in;
    logic       y_valid;
    logic       frame_done;
    logic       ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       ram1_we;
    logic       ram2_we;
    logic       front_sel;
    logic       drop;
    logic [7:0] swap_count;

    int n_checks = 0;
    int n_fail   = 0;

    terrain_buffer_writer #(
        .COLS  (COLS),
        .Y_MAX (Y_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .y_in       (y_in),
        .y_valid    (y_valid),
        .frame_done (frame_done),
        .ready      (ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ram1_we    (ram1_we),
        .ram2_we    (ram2_we),
        .front_sel  (front_sel),
        .drop       (drop),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int y);
        return (y > Y_MAX) ? Y_MAX : y;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, ".ready"},      ready,      0);
        check({tag, ".wr_addr"},    wr_addr,    0);
        check({tag, ".wr_data"},    wr_data,    0);
        check({tag, ".ram1_we"},    ram1_we,    0);
        check({tag, ".ram2_we"},    ram2_we,    0);
        check({tag, ".front_sel"},  front_sel,  0);
        check({tag, ".drop"},       drop,       0);
        check({tag, ".swap_count"}, swap_count, 0);
    endtask

    // Streams n consecutive samples y = (col + y_off) mod 256, optionally with
    // frame_done on sample fd_idx, checking each write one cycle later.
    task automatic run_fill(input int n, input int fd_idx, input logic exp_front,
                            input int y_off, input int exp_swaps);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("fill.ram1_we",    ram1_we,    exp_front ? 1 : 0);
                check("fill.ram2_we",    ram2_we,    exp_front ? 0 : 1);
                check("fill.wr_addr",    wr_addr,    i - 1);
                check("fill.wr_data",    wr_data,    clamp((i - 1 + y_off) % 256));
                check("fill.ready",      ready,      (i - 1 == COLS - 1) ? 0 : 1);
                check("fill.front_sel",  front_sel,  exp_front);
                check("fill.swap_count", swap_count, exp_swaps);
                check("fill.drop",       drop,       0);
            end
            if (i < n) begin
                y_valid    = 1'b1;
                y_in       = 8'((i + y_off) % 256);
                frame_done = (i == fd_idx);
            end else begin
                y_valid    = 1'b0;
                frame_done = 1'b0;
            end
        end
    endtask

    task automatic do_swap(input logic exp_front, input int exp_swaps);
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        check("swap.front_sel",  front_sel,  exp_front);
        check("swap.swap_count", swap_count, exp_swaps);
        check("swap.ready",      ready,      1);
        check("swap.ram1_we",    ram1_we,    0);
        check("swap.ram2_we",    ram2_we,    0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        y_in       = 8'd0;
        y_valid    = 1'b0;
        frame_done = 1'b0;

        #2 reset = 1'b1;
        #1 check_reset_state("reset_async");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // IDLE: frame_done ignored, no ready
        @(negedge clk);
        check("idle.ready", ready, 0);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        check("idle_fd.front_sel",  front_sel,  0);
        check("idle_fd.swap_count", swap_count, 0);
        check("idle_fd.ready",      ready,      0);

        // Start, then drop start: filling continues
        start = 1'b1;
        @(negedge clk);
        check("start.ready", ready, 1);
        start = 1'b0;
        @(negedge clk);
        check("start_low.ready",   ready,   1);
        check("start_low.ram2_we", ram2_we, 0);

        // First full fill into buffer 2, y = column index
        run_fill(COLS, -1, 1'b0, 0, 0);

        // y_valid held 3 cycles in WAIT_SWAP: drops, no writes
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("wait_drop.drop",    drop,    1);
                check("wait_drop.ram1_we", ram1_we, 0);
                check("wait_drop.ram2_we", ram2_we, 0);
                check("wait_drop.ready",   ready,   0);
            end
            y_valid = (k < 3);
        end
        @(negedge clk);
        check("wait_drop_end.drop",      drop,      0);
        check("wait_drop_end.front_sel", front_sel, 0);

        // Swap, then fill buffer 1 with frame_done at column 50 ignored
        do_swap(1'b1, 1);
        run_fill(COLS, 50, 1'b1, 100, 1);

        // Swap back, then frame_done coincident with final sample
        do_swap(1'b0, 2);
        run_fill(COLS, COLS - 1, 1'b0, 33, 2);
        repeat (3) begin
            @(negedge clk);
            check("hold_wait.ready",      ready,      0);
            check("hold_wait.front_sel",  front_sel,  0);
            check("hold_wait.swap_count", swap_count, 2);
            check("hold_wait.ram2_we",    ram2_we,    0);
        end
        do_swap(1'b1, 3);

        // Reset asserted at column 80 of a fill
        run_fill(80, -1, 1'b1, 7, 3);
        y_valid = 1'b1;
        #2 reset = 1'b1;
        #1 check_reset_state("reset_mid");
        @(negedge clk);
        check_reset_state("reset_held");
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_reset.ram1_we", ram1_we, 0);
            check("post_reset.ram2_we", ram2_we, 0);
            check("post_reset.ready",   ready,   0);
            check("post_reset.drop",    drop,    1);
        end
        y_valid = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        check("restart.ready", ready, 1);
        start   = 1'b0;
        y_in    = 8'd200;
        y_valid = 1'b1;
        @(negedge clk);
        y_valid = 1'b0;
        check("restart.ram2_we", ram2_we, 1);
        check("restart.ram1_we", ram1_we, 0);
        check("restart.wr_addr", wr_addr, 0);
        check("restart.wr_data", wr_data, Y_MAX);
        @(negedge clk);
        check("restart_end.ram2_we", ram2_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
